// File: rtl/bmf_scan_pkg.sv
// Shared types and width helpers for the BMF partition error-scan stage.
// BMF_HAM_HIST_EN (optional) adds a per-sample Hamming-distance histogram.
package bmf_scan_pkg;

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

    localparam int IN_W_D  = 9;
    localparam int OUT_W_D = 8;
    localparam int NPAT    = 1 << IN_W_D;
    localparam int HAM_W   = IN_W_D + $clog2(OUT_W_D + 1);
    localparam int ABS_W   = IN_W_D + OUT_W_D;

    function automatic int npat(input int in_w);
        return 1 << in_w;
    endfunction

    function automatic int ham_w(input int in_w, input int out_w);
        return in_w + $clog2(out_w + 1);
    endfunction

    function automatic int abs_w(input int in_w, input int out_w);
        return in_w + out_w;
    endfunction

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < 32; i++) c += 32'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/bmf_err_acc.sv
// Error-metric accumulators fed by qualified approx/exact sample pairs.
// BMF_HAM_HIST_EN adds one counter per possible Hamming distance.
module bmf_err_acc
    import bmf_scan_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clr,
    input  logic                            upd,
    input  logic [OUT_W-1:0]                approx,
    input  logic [OUT_W-1:0]                exact,
`ifdef BMF_HAM_HIST_EN
    output logic [(OUT_W+1)*(IN_W+1)-1:0]   ham_hist,
`endif
    output logic [IN_W:0]                   err_cnt,
    output logic [ham_w(IN_W, OUT_W)-1:0]   ham_sum,
    output logic [abs_w(IN_W, OUT_W)-1:0]   abs_sum,
    output logic [OUT_W-1:0]                abs_max
);

    localparam int HW = ham_w(IN_W, OUT_W);
    localparam int AW = abs_w(IN_W, OUT_W);

    logic [OUT_W-1:0] diff;
    logic [HW-1:0]    pc;
    logic [OUT_W:0]   sd;
    logic [OUT_W:0]   ad;
    logic [OUT_W-1:0] a;

    // Difference taken one bit wider so the sign survives, then folded to magnitude.
    always_comb begin
        diff = approx ^ exact;
        pc   = HW'(popcount(32'(diff)));
        sd   = {1'b0, approx} - {1'b0, exact};
        ad   = sd[OUT_W] ? -sd : sd;
        a    = ad[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
            ham_sum <= '0;
            abs_sum <= '0;
            abs_max <= '0;
        end else if (clr) begin
            err_cnt <= '0;
            ham_sum <= '0;
            abs_sum <= '0;
            abs_max <= '0;
        end else if (upd) begin
            err_cnt <= err_cnt + (IN_W+1)'(diff != '0);
            ham_sum <= ham_sum + pc;
            abs_sum <= abs_sum + AW'(a);
            if (a > abs_max) abs_max <= a;
        end
    end

`ifdef BMF_HAM_HIST_EN
    for (genvar h = 0; h <= OUT_W; h++) begin : g_bin
        logic [IN_W:0] bin;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                         bin <= '0;
            else if (clr)                       bin <= '0;
            else if (upd && pc == HW'(h))       bin <= bin + (IN_W+1)'(1);
        end
        assign ham_hist[h*(IN_W+1) +: IN_W+1] = bin;
    end
`endif

endmodule

// File: rtl/bmf_part_err_scan.sv
// Exhaustive pattern sweep around one BMF partition: FSM, pattern counter, valid pipe.
// BMF_HAM_HIST_EN exposes the Hamming-distance histogram port.
module bmf_part_err_scan
    import bmf_scan_pkg::*;
#(
    parameter int IN_W  = 9,
    parameter int OUT_W = 8,
    parameter int LAT   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            pause,
    output logic [IN_W-1:0]                 pat,
    output logic                            pat_vld,
    input  logic [OUT_W-1:0]                approx_in,
    input  logic [OUT_W-1:0]                exact_in,
    output logic                            busy,
    output logic                            done,
`ifdef BMF_HAM_HIST_EN
    output logic [(OUT_W+1)*(IN_W+1)-1:0]   ham_hist,
`endif
    output logic [IN_W:0]                   err_cnt,
    output logic [ham_w(IN_W, OUT_W)-1:0]   ham_sum,
    output logic [abs_w(IN_W, OUT_W)-1:0]   abs_sum,
    output logic [OUT_W-1:0]                abs_max
);

    state_t          state, nxt;
    logic [IN_W-1:0] cnt;
    logic [IN_W-1:0] pat_q;
    logic            issue;
    logic            clr;
    logic [LAT:0]    vld_pipe;

    assign issue   = (state == SWEEP) && !pause;
    assign pat_vld = issue;
    // pat follows the counter on issue, otherwise holds the last issued pattern.
    assign pat     = issue ? cnt : pat_q;
    assign busy    = (state == SWEEP) || (state == DRAIN);
    assign done    = (state == DONE);

    if (LAT > 0) begin : g_pipe
        logic [LAT-1:0] sr;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sr <= '0;
            else begin
                sr[0] <= pat_vld;
                for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
            end
        end
        assign vld_pipe = {sr, pat_vld};
    end else begin : g_nopipe
        assign vld_pipe = pat_vld;
    end

    always_comb begin
        nxt = state;
        clr = 1'b0;
        case (state)
            IDLE, DONE: if (start) begin
                nxt = SWEEP;
                clr = 1'b1;
            end
            // With LAT=0 the last sample lands on the same edge that enters DONE.
            SWEEP: if (issue && &cnt) nxt = (LAT > 0) ? DRAIN : DONE;
            DRAIN: if (vld_pipe == '0) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pat_q <= '0;
        end else begin
            state <= nxt;
            if (clr) cnt <= '0;
            else if (issue) begin
                cnt   <= cnt + IN_W'(1);
                pat_q <= cnt;
            end
        end
    end

    bmf_err_acc #(.IN_W(IN_W), .OUT_W(OUT_W)) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .upd      (vld_pipe[LAT]),
        .approx   (approx_in),
        .exact    (exact_in),
`ifdef BMF_HAM_HIST_EN
        .ham_hist (ham_hist),
`endif
        .err_cnt  (err_cnt),
        .ham_sum  (ham_sum),
        .abs_sum  (abs_sum),
        .abs_max  (abs_max)
    );

endmodule
